// File: rtl/timer_loader.sv
// timer_loader: keypad-side digit loader for the microwave countdown timer.
// Collects decimal key presses into a 3-digit MM:SS entry buffer. On start it
// sends minutes, seconds-tens and seconds-ones to the timer over the serial
// digit-load interface (data plus active-low loadn strobe).
//
// Optional feature macro: TIMER_LOADER_CLAMP_EN
//   defined   - a seconds-tens digit above 5 is sent as 5 (max 9:59)
//   undefined - digits are sent exactly as entered
//
// Parameters:
//   GAP_CYCLES  loadn-high cycles after the minutes and tens strobes (1..15)
//
// Ports:
//   clock       system clock, rising edge
//   clearn      synchronous active-low reset
//   key_valid   one-cycle strobe, key_digit valid
//   key_digit   keypad code, only 0..9 accepted
//   key_clear   one-cycle strobe, zero the entry buffer
//   start       one-cycle strobe, transfer the buffer to the timer
//   data        digit presented to the timer
//   loadn       active-low load strobe to the timer
//   busy        high while a transfer is in progress
//   load_done   one-cycle pulse when the transfer completes
//   entry_mins  buffer minutes digit (display)
//   entry_tens  buffer seconds-tens digit (display)
//   entry_ones  buffer seconds-ones digit (display)
module timer_loader #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
    input  logic       start,
    output logic [3:0] data,
    output logic       loadn,
    output logic       busy,
    output logic       load_done,
    output logic [3:0] entry_mins,
    output logic [3:0] entry_tens,
    output logic [3:0] entry_ones
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MIN,
        GAP1,
        LOAD_TENS,
        GAP2,
        LOAD_ONES,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   gap_cnt;
    logic [DIGIT_W-1:0] xfer_tens;
    logic [DIGIT_W-1:0] xfer_ones;
    logic [DIGIT_W-1:0] tens_xfer_c;

    // Tens digit as it will be latched at start (display copy is never altered).
    always_comb begin
        tens_xfer_c = entry_tens;
`ifdef TIMER_LOADER_CLAMP_EN
        if (entry_tens > DIGIT_W'(5)) begin
            tens_xfer_c = DIGIT_W'(5);
        end
`endif
    end

    // Transfer sequencer and entry buffer; every output is a register.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            xfer_tens  <= '0;
            xfer_ones  <= '0;
            data       <= '0;
            loadn      <= 1'b1;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            entry_mins <= '0;
            entry_tens <= '0;
            entry_ones <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_clear) begin
                        entry_mins <= '0;
                        entry_tens <= '0;
                        entry_ones <= '0;
                    end else if (start) begin
                        // Minutes go straight onto the bus; the rest are latched
                        // so later input activity cannot disturb them.
                        xfer_tens <= tens_xfer_c;
                        xfer_ones <= entry_ones;
                        data      <= entry_mins;
                        loadn     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LOAD_MIN;
                    end else if (key_valid && (key_digit <= DIGIT_W'(9))) begin
                        entry_mins <= entry_tens;
                        entry_tens <= entry_ones;
                        entry_ones <= key_digit;
                    end
                end

                LOAD_MIN: begin
                    loadn   <= 1'b1;
                    gap_cnt <= CNT_W'(GAP_CYCLES - 1);
                    state   <= GAP1;
                end

                GAP1: begin
                    if (gap_cnt == '0) begin
                        data  <= xfer_tens;
                        loadn <= 1'b0;
                        state <= LOAD_TENS;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end
                end

                LOAD_TENS: begin
                    loadn   <= 1'b1;
                    gap_cnt <= CNT_W'(GAP_CYCLES - 1);
                    state   <= GAP2;
                end

                GAP2: begin
                    if (gap_cnt == '0) begin
                        data  <= xfer_ones;
                        loadn <= 1'b0;
                        state <= LOAD_ONES;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end
                end

                LOAD_ONES: begin
                    loadn      <= 1'b1;
                    load_done  <= 1'b1;
                    entry_mins <= '0;
                    entry_tens <= '0;
                    entry_ones <= '0;
                    state      <= DONE;
                end

                DONE: begin
                    data      <= '0;
                    busy      <= 1'b0;
                    load_done <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    data      <= '0;
                    loadn     <= 1'b1;
                    busy      <= 1'b0;
                    load_done <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_loader.sv
// tb_timer_loader: randomized bench for timer_loader. Two instances (gap 1 and
// gap 3) share one input stream; each is compared every cycle against a
// transaction-level model that expands a start into its expected output trace.
module tb_timer_loader;

    localparam int NUM_CYCLES = 4000;

    logic       clock = 1'b0;
    logic       clearn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       key_clear;
    logic       start;

    logic [3:0] data_o     [2];
    logic       loadn_o    [2];
    logic       busy_o     [2];
    logic       done_o     [2];
    logic [3:0] mins_o     [2];
    logic [3:0] tens_o     [2];
    logic [3:0] ones_o     [2];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    timer_loader #(.GAP_CYCLES(1)) u_gap1 (
        .clock(clock), .clearn(clearn), .key_valid(key_valid), .key_digit(key_digit),
        .key_clear(key_clear), .start(start), .data(data_o[0]), .loadn(loadn_o[0]),
        .busy(busy_o[0]), .load_done(done_o[0]), .entry_mins(mins_o[0]),
        .entry_tens(tens_o[0]), .entry_ones(ones_o[0])
    );

    timer_loader #(.GAP_CYCLES(3)) u_gap3 (
        .clock(clock), .clearn(clearn), .key_valid(key_valid), .key_digit(key_digit),
        .key_clear(key_clear), .start(start), .data(data_o[1]), .loadn(loadn_o[1]),
        .busy(busy_o[1]), .load_done(done_o[1]), .entry_mins(mins_o[1]),
        .entry_tens(tens_o[1]), .entry_ones(ones_o[1])
    );

    // One expected output cycle; clr marks the cycle in which the buffer empties.
    typedef struct packed {
        logic       loadn;
        logic [3:0] data;
        logic       busy;
        logic       done;
        logic       clr;
    } exp_t;

    exp_t tq [2][$];
    int   gap [2] = '{1, 3};

    int         buf_m [2];
    int         buf_t [2];
    int         buf_o [2];
    logic       e_loadn [2];
    logic [3:0] e_data  [2];
    logic       e_busy  [2];
    logic       e_done  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic ln, input int d, input logic b,
                                input logic dn, input logic c);
        exp_t e;
        e.loadn = ln;
        e.data  = 4'(d);
        e.busy  = b;
        e.done  = dn;
        e.clr   = c;
        return e;
    endfunction

    task automatic apply(input int u, input exp_t e);
        e_loadn[u] = e.loadn;
        e_data[u]  = e.data;
        e_busy[u]  = e.busy;
        e_done[u]  = e.done;
        if (e.clr) begin
            buf_m[u] = 0;
            buf_t[u] = 0;
            buf_o[u] = 0;
        end
    endtask

    // Expand a start into the full per-cycle trace of the transfer.
    task automatic build_trace(input int u);
        int tt;
        tt = buf_t[u];
`ifdef TIMER_LOADER_CLAMP_EN
        if (tt > 5) tt = 5;
`endif
        tq[u].push_back(mk(1'b0, buf_m[u], 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < gap[u]; i++) tq[u].push_back(mk(1'b1, buf_m[u], 1'b1, 1'b0, 1'b0));
        tq[u].push_back(mk(1'b0, tt, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < gap[u]; i++) tq[u].push_back(mk(1'b1, tt, 1'b1, 1'b0, 1'b0));
        tq[u].push_back(mk(1'b0, buf_o[u], 1'b1, 1'b0, 1'b0));
        tq[u].push_back(mk(1'b1, buf_o[u], 1'b1, 1'b1, 1'b1));
        tq[u].push_back(mk(1'b1, 0, 1'b0, 1'b0, 1'b0));
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step(input int u);
        if (!clearn) begin
            tq[u].delete();
            apply(u, mk(1'b1, 0, 1'b0, 1'b0, 1'b1));
        end else if (tq[u].size() > 0) begin
            apply(u, tq[u].pop_front());
        end else if (key_clear) begin
            apply(u, mk(1'b1, 0, 1'b0, 1'b0, 1'b1));
        end else if (start) begin
            build_trace(u);
            apply(u, tq[u].pop_front());
        end else if (key_valid && key_digit <= 4'd9) begin
            buf_m[u] = buf_t[u];
            buf_t[u] = buf_o[u];
            buf_o[u] = int'(key_digit);
        end
    endtask

    task automatic compare(input int u);
        string p;
        p = $sformatf("gap%0d", gap[u]);
        check({p, ".loadn"}, 32'(loadn_o[u]), 32'(e_loadn[u]));
        check({p, ".data"},  32'(data_o[u]),  32'(e_data[u]));
        check({p, ".busy"},  32'(busy_o[u]),  32'(e_busy[u]));
        check({p, ".load_done"}, 32'(done_o[u]), 32'(e_done[u]));
        check({p, ".entry"}, 32'({mins_o[u], tens_o[u], ones_o[u]}),
              32'({4'(buf_m[u]), 4'(buf_t[u]), 4'(buf_o[u])}));
    endtask

    initial begin
        int r;
        clearn    = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        key_clear = 1'b0;
        start     = 1'b0;
        for (int u = 0; u < 2; u++) begin
            buf_m[u] = 0; buf_t[u] = 0; buf_o[u] = 0;
            e_loadn[u] = 1'b1; e_data[u] = 4'd0; e_busy[u] = 1'b0; e_done[u] = 1'b0;
        end

        repeat (2) begin
            @(posedge clock);
            model_step(0);
            model_step(1);
        end

        for (int c = 0; c < NUM_CYCLES; c++) begin
            @(negedge clock);
            compare(0);
            compare(1);

            r         = int'($urandom_range(0, 99));
            clearn    = (r >= 1);
            key_clear = (r >= 1 && r < 5);
            start     = (r >= 4 && r < 16);
            key_valid = (r >= 10 && r < 75);
            key_digit = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9))
                                                   : 4'($urandom_range(10, 15));

            @(posedge clock);
            model_step(0);
            model_step(1);
        end

        @(negedge clock);
        compare(0);
        compare(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_loader.md
Name: timer_loader

Overview:
Keypad-side digit loader for the microwave countdown timer. It collects decimal key presses into a 3-digit MM:SS entry buffer (minutes, seconds-tens, seconds-ones). On start, it drives the timer's serial load interface (data plus active-low loadn strobe) with the digits in the order minutes, seconds-tens, seconds-ones. It sits between the keypad decoder and the timer, and is the transmitting end of the timer's digit-load interface.

Parameters:
GAP_CYCLES, 1, loadn-high cycles inserted after each of the minutes and seconds-tens strobes; legal range 1..15.

Ports:
clock      input   1  system clock; all state updates on the rising edge
clearn     input   1  synchronous, active-low reset
key_valid  input   1  one-cycle strobe; key_digit is valid
key_digit  input   4  keypad code; only 0..9 accepted
key_clear  input   1  one-cycle strobe; zero the entry buffer
start      input   1  one-cycle strobe; transfer the buffer to the timer
data       output  4  digit presented to the timer
loadn      output  1  active-low load strobe to the timer
busy       output  1  high while a transfer is in progress
load_done  output  1  one-cycle pulse when the transfer completes
entry_mins output  4  buffer minutes digit, for display
entry_tens output  4  buffer seconds-tens digit, for display
entry_ones output  4  buffer seconds-ones digit, for display

Behaviour:
- Reset (clearn=0 at an edge): state IDLE, data=0, loadn=1, busy=0, load_done=0, all entry digits 0. Reset wins over every other input and aborts any transfer in progress immediately; no further loadn pulses follow.
- All outputs are registered.
- IDLE input priority: key_clear > start > key_valid.
  - key_clear: all three entry digits become 0.
  - key_valid with key_digit<=9: shift left. mins<=tens, tens<=ones, ones<=key_digit; the old mins is discarded.
  - key_valid with key_digit>=10: ignored, buffer unchanged.
  - start: latch the buffer into the transfer registers, set busy=1, go to LOAD_MIN. A simultaneous key is discarded. A start with an all-zero buffer still performs a full transfer.
- States: IDLE -> LOAD_MIN -> GAP1 -> LOAD_TENS -> GAP2 -> LOAD_ONES -> DONE -> IDLE.
  - LOAD_x: exactly one cycle with loadn=0 and data=the latched digit.
  - GAPn: GAP_CYCLES cycles with loadn=1 and data held at the previous digit.
  - DONE: one cycle with loadn=1, load_done=1, busy=1, entry buffer cleared to 0.
  - The cycle after DONE: IDLE, busy=0, load_done=0, data=0.
- Latency with GAP_CYCLES=1 and start sampled at edge k:
  - loadn low during cycles k+1 (mins), k+3 (tens), k+5 (ones).
  - load_done high in cycle k+6; busy low from cycle k+7.
- While busy=1, key_valid, key_clear and start are ignored and the entry buffer is frozen, except for the clear in DONE.
- The latched digits are immune to input activity during the transfer.

Optional Feature:
TIMER_LOADER_CLAMP_EN
- Defined: at start, a seconds-tens digit greater than 5 is latched as 5, so the maximum transferred value is 9:59. The display outputs are not altered.
- Undefined: digits are transferred exactly as entered; the tens digit is not range-checked.

Test Plan:
- Reset then idle: clearn=0 for 2 cycles -> loadn=1, data=0, busy=0, entry digits 0/0/0.
- Keys 1,3,0 then start, GAP_CYCLES=1 -> entry 1/3/0. Strobes: loadn low with data=1 at k+1, data=3 at k+3, data=0 at k+5. load_done high at k+6; entry reads 0/0/0 afterwards.
- Keys 4,5,6,7 then key_digit=12 -> entry 5/6/7; the code-12 key leaves the buffer unchanged.
- key_valid=1 (digit 9) together with start on buffer 0/1/0 -> transfer sends 0,1,0; digit 9 is lost. key_clear together with start -> buffer 0/0/0 and no transfer.
- During a transfer, pulse key_valid (digit 8) and start -> no extra loadn pulses; the transferred digits are unchanged; entry is 0/0/0 after DONE. Then set clearn=0 during GAP1 -> next cycle loadn=1, busy=0, no tens or ones strobe follows.
- Entry 0/8/0 then start: with TIMER_LOADER_CLAMP_EN defined, the second strobe carries data=5; without it, data=8. Repeat with GAP_CYCLES=3 -> strobes 4 cycles apart.
